// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready request channel to APB requester for the I2C register file
// Optional ACCESS wait-state abort is enabled with APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int RDATA_LAG      = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} state_t;

  state_t state, state_nx;
  logic   accept;
  logic   done;
  logic   capture;
  logic   abort;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts PREADY-low ACCESS cycles; cleared whenever not in ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      wait_cnt <= '0;
    else if (state != ACCESS)
      wait_cnt <= '0;
    else if (!PREADY)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign abort = (state == ACCESS) && !PREADY &&
                 (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No wait-state limit: ACCESS waits for PREADY indefinitely.
  assign abort = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE:   if (accept) state_nx = SETUP;
      SETUP:  state_nx = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          if (!PWRITE && (RDATA_LAG != 0)) begin
            state_nx = RDWAIT;
          end else begin
            state_nx = IDLE;
            done     = 1'b1;
            capture  = !PWRITE;
          end
        end else if (abort) begin
          state_nx = IDLE;
        end
      end
      RDWAIT: begin
        state_nx = IDLE;
        done     = 1'b1;
        capture  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // APB and response outputs are registered from the next state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
      end
      PSELx     <= (state_nx == SETUP) || (state_nx == ACCESS);
      PENABLE   <= (state_nx == ACCESS);
      rsp_valid <= done | abort;
      rsp_err   <= abort;
      if (capture)
        rsp_rdata <= PRDATA;
    end
  end

endmodule
